// File: rtl/sif_pkg.sv
// Shared SIF write-path types: widths and the write-buffer entry.
// Optional drop counter in sif_wr_fifo: SIF_WR_FIFO_DROP_CNT_EN.
package sif_pkg;

   localparam int SIF_AW = 16;
   localparam int SIF_DW = 16;

   typedef struct packed {
      logic [SIF_AW-1:0] addr;
      logic [SIF_DW-1:0] data;
   } sif_wr_t;

endpackage

// File: rtl/sif_wr_fifo_if.sv
// Write strobe in (wa_*) and valid/ready drain out (wb_*).
// The slave side is the FIFO; the master side is its environment.
interface sif_wr_fifo_if
   import sif_pkg::*;
#(
   parameter int AW = SIF_AW,
   parameter int DW = SIF_DW
);

   logic          wa_wr_s;
   logic [AW-1:0] wa_addr;
   logic [DW-1:0] wa_data_wr;
   logic          wb_valid;
   logic          wb_ready;
   logic [AW-1:0] wb_addr;
   logic [DW-1:0] wb_data;

   modport master (
      output wa_wr_s, wa_addr, wa_data_wr, wb_ready,
      input  wb_valid, wb_addr, wb_data
   );

   modport slave (
      input  wa_wr_s, wa_addr, wa_data_wr, wb_ready,
      output wb_valid, wb_addr, wb_data
   );

endinterface

// File: rtl/sif_fifo_ctrl.sv
// Pointer bookkeeping for the write buffer: wrap-bit pointers,
// full/empty, level and almost-full.
module sif_fifo_ctrl #(
   parameter int DEPTH     = 8,
   parameter int AFULL_LVL = 6
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_req,
   input  logic                     rd_req,
   output logic                     push,
   output logic                     pop,
   output logic [$clog2(DEPTH)-1:0] wr_idx,
   output logic [$clog2(DEPTH)-1:0] rd_idx,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     afull
);

   localparam int IW = $clog2(DEPTH);
   localparam int LW = IW + 1;

   logic [LW-1:0] wr_ptr;
   logic [LW-1:0] rd_ptr;

   assign wr_idx = wr_ptr[IW-1:0];
   assign rd_idx = rd_ptr[IW-1:0];
   assign empty  = (wr_ptr == rd_ptr);
   assign full   = (wr_idx == rd_idx) && (wr_ptr[IW] != rd_ptr[IW]);
   assign level  = wr_ptr - rd_ptr;
   assign afull  = (level >= LW'(AFULL_LVL));

   // A full buffer still accepts a write when the head leaves on the same edge
   assign pop  = !empty && rd_req;
   assign push = wr_req && (!full || pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + LW'(1);
         if (pop)  rd_ptr <= rd_ptr + LW'(1);
      end
   end

endmodule

// File: rtl/sif_wr_fifo.sv
// SIF write buffer: captures wa_wr_s pulses, drains to a valid/ready sink.
// Define SIF_WR_FIFO_DROP_CNT_EN to add the saturating drop_cnt port.
module sif_wr_fifo
   import sif_pkg::*;
#(
   parameter int DEPTH     = 8,
   parameter int AW        = SIF_AW,
   parameter int DW        = SIF_DW,
   parameter int AFULL_LVL = 6
) (
   input  logic                   clk,
   input  logic                   rst,
   sif_wr_fifo_if.slave           bus,
   input  logic                   ovf_clr,
   output logic [$clog2(DEPTH):0] fifo_level,
   output logic                   afull,
   output logic                   ovf
`ifdef SIF_WR_FIFO_DROP_CNT_EN
   ,
   output logic [7:0]             drop_cnt
`endif
);

   localparam int IW = $clog2(DEPTH);

   sif_wr_t         mem [DEPTH];
   logic            push;
   logic            pop;
   logic            empty;
   logic            full;
   logic [IW-1:0]   wr_idx;
   logic [IW-1:0]   rd_idx;
   logic            drop;

   sif_fifo_ctrl #(
      .DEPTH     (DEPTH),
      .AFULL_LVL (AFULL_LVL)
   ) u_ctrl (
      .clk    (clk),
      .rst    (rst),
      .wr_req (bus.wa_wr_s),
      .rd_req (bus.wb_ready),
      .push   (push),
      .pop    (pop),
      .wr_idx (wr_idx),
      .rd_idx (rd_idx),
      .empty  (empty),
      .full   (full),
      .level  (fifo_level),
      .afull  (afull)
   );

   assign drop         = bus.wa_wr_s && full && !pop;
   assign bus.wb_valid = !empty;
   assign bus.wb_addr  = AW'(mem[rd_idx].addr);
   assign bus.wb_data  = DW'(mem[rd_idx].data);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push) begin
         mem[wr_idx] <= '{addr: SIF_AW'(bus.wa_addr),
                          data: SIF_DW'(bus.wa_data_wr)};
      end
   end

   // Set beats clear so a loss on the clearing edge is never hidden
   always_ff @(posedge clk or posedge rst) begin
      if (rst)          ovf <= 1'b0;
      else if (drop)    ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
   end

`ifdef SIF_WR_FIFO_DROP_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                        drop_cnt <= '0;
      else if (ovf_clr)               drop_cnt <= {7'd0, drop};
      else if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 8'd1;
   end
`endif

endmodule
